// File: rtl/mem_access_s5.sv
// Stage-5 memory access: RISC-V loads/stores over a req/ack data bus and a
// registered writeback bundle, stalling the s4/s5 latch while an access is open.
module mem_access_s5 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  rd_in,
  input  logic [6:0]  instr_flags_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err,
  output logic        mem_err_cause
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic             r_err_pend, w_err_pend_nxt;
  logic             r_cause_pend, w_cause_pend_nxt;

  logic             w_req_nxt, w_we_nxt;
  logic [31:0]      w_addr_nxt, w_wdata_nxt;
  logic [3:0]       w_be_nxt;
  logic             w_wb_valid_nxt, w_wb_we_nxt;
  logic [4:0]       w_wb_rd_nxt;
  logic [31:0]      w_wb_data_nxt;
  logic             w_err_nxt, w_err_cause_nxt;
  logic             w_stall;

  logic             w_mem_op, w_is_load, w_misaligned, w_rd_we;
  logic [1:0]       w_size;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata, w_ld_data;
  logic [7:0]       w_ld_byte;
  logic [15:0]      w_ld_half;

  // Decode and lane formatting; funct3[1:0] gives size (1x = word), funct3[2] = unsigned
  always_comb begin
    w_mem_op     = instr_flags_in[1] | instr_flags_in[2];
    w_is_load    = instr_flags_in[1];
    w_rd_we      = instr_flags_in[0] & (rd_in != 5'd0);
    w_size       = funct3_in[1:0];
    w_misaligned = ((w_size == 2'b01) & alu_result_in[0]) |
                   (w_size[1] & (alu_result_in[1:0] != 2'b00));

    case (w_size)
      2'b00: begin
        w_st_wdata = {4{store_data_in[7:0]}};
        w_st_be    = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{store_data_in[15:0]}};
        w_st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = store_data_in;
        w_st_be    = 4'b1111;
      end
    endcase

    case (alu_result_in[1:0])
      2'b00:   w_ld_byte = r_rdata[7:0];
      2'b01:   w_ld_byte = r_rdata[15:8];
      2'b10:   w_ld_byte = r_rdata[23:16];
      default: w_ld_byte = r_rdata[31:24];
    endcase
    w_ld_half = alu_result_in[1] ? r_rdata[31:16] : r_rdata[15:0];

    case (w_size)
      2'b00:   w_ld_data = funct3_in[2] ? {24'd0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = funct3_in[2] ? {16'd0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = r_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rdata_nxt      = r_rdata;
    w_err_pend_nxt   = r_err_pend;
    w_cause_pend_nxt = r_cause_pend;
    w_req_nxt        = dmem_req;
    w_we_nxt         = dmem_we;
    w_addr_nxt       = dmem_addr;
    w_wdata_nxt      = dmem_wdata;
    w_be_nxt         = dmem_be;
    w_wb_valid_nxt   = 1'b0;
    w_wb_we_nxt      = 1'b0;
    w_wb_rd_nxt      = wb_rd;
    w_wb_data_nxt    = wb_data;
    w_err_nxt        = 1'b0;
    w_err_cause_nxt  = mem_err_cause;
    w_stall          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_mem_op) begin
          w_wb_valid_nxt = (instr_flags_in != 7'd0);
          w_wb_we_nxt    = w_rd_we;
          w_wb_rd_nxt    = rd_in;
          w_wb_data_nxt  = alu_result_in;
        end else if (w_misaligned) begin
          w_stall          = 1'b1;
          w_err_pend_nxt   = 1'b1;
          w_cause_pend_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end else begin
          w_stall        = 1'b1;
          w_req_nxt      = 1'b1;
          w_we_nxt       = ~w_is_load;
          w_addr_nxt     = {alu_result_in[31:2], 2'b00};
          w_wdata_nxt    = w_is_load ? 32'd0 : w_st_wdata;
          w_be_nxt       = w_is_load ? 4'b1111 : w_st_be;
          w_cnt_nxt      = '0;
          w_err_pend_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        // An ack on the final wait cycle still wins over the timeout
        if (dmem_ack) begin
          w_rdata_nxt = dmem_rdata;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_req_nxt        = 1'b0;
          w_err_pend_nxt   = 1'b1;
          w_cause_pend_nxt = 1'b0;
          w_state_nxt      = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_wb_valid_nxt = 1'b1;
        w_wb_rd_nxt    = rd_in;
        if (r_err_pend) begin
          w_wb_data_nxt   = 32'd0;
          w_err_nxt       = 1'b1;
          w_err_cause_nxt = r_cause_pend;
        end else if (w_is_load) begin
          w_wb_we_nxt   = w_rd_we;
          w_wb_data_nxt = w_ld_data;
        end else begin
          w_wb_data_nxt = 32'd0;
        end
        w_err_pend_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stall_out = w_stall & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rdata       <= 32'd0;
      r_err_pend    <= 1'b0;
      r_cause_pend  <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_be       <= 4'd0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      mem_err       <= 1'b0;
      mem_err_cause <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rdata       <= w_rdata_nxt;
      r_err_pend    <= w_err_pend_nxt;
      r_cause_pend  <= w_cause_pend_nxt;
      dmem_req      <= w_req_nxt;
      dmem_we       <= w_we_nxt;
      dmem_addr     <= w_addr_nxt;
      dmem_wdata    <= w_wdata_nxt;
      dmem_be       <= w_be_nxt;
      wb_valid      <= w_wb_valid_nxt;
      wb_we         <= w_wb_we_nxt;
      wb_rd         <= w_wb_rd_nxt;
      wb_data       <= w_wb_data_nxt;
      mem_err       <= w_err_nxt;
      mem_err_cause <= w_err_cause_nxt;
    end
  end

endmodule
